// File: rtl/ram_bank_mp.sv
// ram_bank_mp: single-write, multi-read word RAM with byte strobes,
// pipelined reads and a sequential post-reset clear engine.
//
// Ports:
//   clk, nreset                  clock (rising edge), async active-low reset
//   init_busy                    high while the clear engine runs
//   write_en/write_strb          write request and per-byte enables
//   addr_write/data_write        write word address and data
//   write_err                    one-cycle pulse after an out-of-range write
//   read_en[READ_PORTS]          per-port read request
//   addr_read/data_read          packed per-port address / data
//   read_valid/read_err          per-port valid strobe and out-of-range flag
module ram_bank_mp #(
  parameter int unsigned BUS_WIDTH    = 32,
  parameter int unsigned ADDR_BASE    = 0,
  parameter int unsigned MEM_SIZE     = 256,
  parameter int unsigned READ_PORTS   = 2,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned WRITE_MODE   = 0
) (
  input  logic                             clk,
  input  logic                             nreset,
  output logic                             init_busy,
  input  logic                             write_en,
  input  logic [BUS_WIDTH/8-1:0]           write_strb,
  input  logic [BUS_WIDTH-1:0]             addr_write,
  input  logic [BUS_WIDTH-1:0]             data_write,
  output logic                             write_err,
  input  logic [READ_PORTS-1:0]            read_en,
  input  logic [READ_PORTS*BUS_WIDTH-1:0]  addr_read,
  output logic [READ_PORTS*BUS_WIDTH-1:0]  data_read,
  output logic [READ_PORTS-1:0]            read_valid,
  output logic [READ_PORTS-1:0]            read_err
);

  localparam int unsigned BYTES = BUS_WIDTH / 8;
  localparam int unsigned IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [BUS_WIDTH-1:0] BASE  = BUS_WIDTH'(ADDR_BASE);
  localparam logic [BUS_WIDTH-1:0] LIMIT = BUS_WIDTH'(MEM_SIZE);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             clr_we;
  logic             ready;

  logic [BUS_WIDTH-1:0] mem [MEM_SIZE];

  logic [BUS_WIDTH-1:0] w_off;
  logic                 w_in;
  logic [IDX_W-1:0]     w_idx;
  logic                 wr_fire;

  logic [BUS_WIDTH-1:0] r_off  [READ_PORTS];
  logic [IDX_W-1:0]     r_idx  [READ_PORTS];
  logic [READ_PORTS-1:0] r_in;

  // Read pipeline: stage 0 is captured at the accept edge, last stage drives the outputs.
  logic [READ_PORTS-1:0] pv_q  [READ_LATENCY];
  logic [READ_PORTS-1:0] pe_q  [READ_LATENCY];
  logic [BUS_WIDTH-1:0]  pd_q  [READ_LATENCY][READ_PORTS];
  logic [READ_PORTS-1:0] sv_in [READ_LATENCY];
  logic [READ_PORTS-1:0] se_in [READ_LATENCY];
  logic [BUS_WIDTH-1:0]  sd_in [READ_LATENCY][READ_PORTS];

  // Clear-engine state register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      init_busy <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      init_busy <= (state_d == CLEAR);
    end
  end

  // Clear-engine next state: one zeroed word per cycle until the last index.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we    = 1'b1;
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(MEM_SIZE - 1)) begin
          state_d   = READY;
          clr_idx_d = '0;
        end
      end
      READY: begin
        state_d = READY;
      end
    endcase
  end

  assign ready   = (state_q == READY);
  assign w_off   = addr_write - BASE;
  assign w_in    = (w_off < LIMIT);
  assign w_idx   = w_off[IDX_W-1:0];
  assign wr_fire = ready && write_en && w_in;

  // Array update: clear engine has the port during CLEAR, strobed writes otherwise.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx_q] <= '0;
    end else if (wr_fire) begin
      for (int b = 0; b < BYTES; b++) begin
        if (write_strb[b]) mem[w_idx][8*b +: 8] <= data_write[8*b +: 8];
      end
    end
  end

  // Out-of-range write flag, one cycle after the request.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) write_err <= 1'b0;
    else         write_err <= ready && write_en && !w_in;
  end

  // Address decode and pipeline stage inputs.
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      r_off[p]    = addr_read[p*BUS_WIDTH +: BUS_WIDTH] - BASE;
      r_in[p]     = (r_off[p] < LIMIT);
      r_idx[p]    = r_off[p][IDX_W-1:0];
      sd_in[0][p] = '0;
      if (r_in[p]) begin
        sd_in[0][p] = mem[r_idx[p]];
        // Write-first mode forwards the strobed lanes of a same-index write.
        if ((WRITE_MODE != 0) && wr_fire && (w_idx == r_idx[p])) begin
          for (int b = 0; b < BYTES; b++) begin
            if (write_strb[b]) sd_in[0][p][8*b +: 8] = data_write[8*b +: 8];
          end
        end
      end
    end
    sv_in[0] = ready ? read_en : '0;
    se_in[0] = sv_in[0] & ~r_in;
    for (int s = 1; s < READ_LATENCY; s++) begin
      sv_in[s] = pv_q[s-1];
      se_in[s] = pe_q[s-1];
      for (int p = 0; p < READ_PORTS; p++) sd_in[s][p] = pd_q[s-1][p];
    end
  end

  // Read pipeline; data in each stage only advances with a valid so outputs hold.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        pv_q[s] <= '0;
        pe_q[s] <= '0;
        for (int p = 0; p < READ_PORTS; p++) pd_q[s][p] <= '0;
      end
    end else begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        pv_q[s] <= sv_in[s];
        pe_q[s] <= se_in[s];
        for (int p = 0; p < READ_PORTS; p++) begin
          if (sv_in[s][p]) pd_q[s][p] <= sd_in[s][p];
        end
      end
    end
  end

  assign read_valid = pv_q[READ_LATENCY-1];
  assign read_err   = pe_q[READ_LATENCY-1];

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd_out
    assign data_read[p*BUS_WIDTH +: BUS_WIDTH] = pd_q[READ_LATENCY-1][p];
  end

endmodule
